// File: rtl/xfer_pkg.sv
// Shared definitions for the ROM-to-crossing transfer sequencer.
package xfer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        REQ   = 3'd3,
        REL   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/xfer_sequencer_sync2.sv
// Two-flop synchronizer for control bits entering the clk domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xfer_sequencer.sv
// Walks a synchronous ROM and offers each word to a four-phase req/ack crossing,
// with a per-edge acknowledge timeout and a sticky error flag.
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic              busy,
    output logic              err,
    output logic [15:0]       xfer_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic              ack_s;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout_hit;
    logic              done;

    sync2 #(.W(1)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_ack),
        .q   (ack_s)
    );

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        done        = 1'b0;
        wait_inc    = wait_cnt + WAIT_W'(1);
        case (state)
            IDLE:  if (tick && enable && !ack_s) state_nxt = FETCH;
            FETCH: state_nxt = LATCH;
            LATCH: state_nxt = REQ;
            REQ: begin
                if (ack_s) begin
                    state_nxt = REL;
                end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                    state_nxt   = HOLD;
                    timeout_hit = 1'b1;
                end
            end
            REL: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                    state_nxt   = HOLD;
                    timeout_hit = 1'b1;
                end
            end
            HOLD:    if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            tx_data  <= '0;
            xfer_cnt <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == LATCH) tx_data <= rom_q;
            // Address and count only advance on a clean handshake; a timeout retries the same word.
            if (done) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (timeout_hit) err <= 1'b1;
            if ((state_nxt != state) && (state_nxt == REQ || state_nxt == REL))
                wait_cnt <= '0;
            else if (state == REQ || state == REL)
                wait_cnt <= wait_inc;
        end
    end

    // Decoded from state so reset drops the request without waiting for an edge.
    assign tx_req = (state == REQ);
    assign busy   = (state != IDLE);

endmodule
